axi_error_slave: RTL and testbench
==================================

Name: axi_error_slave

Overview:
- Terminating AXI4 slave. It accepts every write and read transaction on its port and completes each one with a fixed error response, carrying no data.
- Sits downstream of an interconnect or master as the default/decode-miss target, so transactions to unmapped addresses finish cleanly instead of hanging.
- Read and write paths are independent. Each path allows one outstanding transaction.

Parameters:
RESP, 2'b11 (DECERR), response code driven on b_resp and every r_resp
R_DATA, '0, constant value driven on r_data for every read beat

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous reset, active-high
master  axi_channel.slave  interface  AXI4 slave side; ID/ADDR/DATA/USER widths come from the interface parameters

Behaviour:
- All handshake outputs are decoded from registered state only. No combinational path from any input to any output.
- Ignored inputs: aw_addr/size/burst/lock/cache/prot/qos/region/user, w_data/strb/user, and ar_* except ar_id and ar_len.
- Constant outputs: b_user = '0, r_user = '0, r_data = R_DATA, b_resp = r_resp = RESP.

Write FSM (W_ADDR, W_DATA, W_RESP):
- W_ADDR: aw_ready=1, w_ready=0, b_valid=0.
  - On aw_valid: latch aw_id into wid, go to W_DATA.
- W_DATA: aw_ready=0, w_ready=1.
  - Each w_valid cycle is an accepted beat.
  - Beat with w_last=1: go to W_RESP.
  - Beat count is not checked; w_last alone ends the burst.
- W_RESP: w_ready=0, b_valid=1, b_id=wid.
  - On b_ready: go to W_ADDR.
- W beats presented before their AW are stalled (w_ready=0 in W_ADDR). This is legal per AXI.
- Minimum cycles per single-beat write: AW at cycle N, W at N+1, B valid at N+2, next AW accepted at N+3 if b_ready is held high.

Read FSM (R_ADDR, R_DATA):
- R_ADDR: ar_ready=1, r_valid=0.
  - On ar_valid: latch ar_id into rid, latch ar_len into 8-bit cnt, go to R_DATA.
- R_DATA: ar_ready=0, r_valid=1, r_id=rid, r_last=(cnt==0).
  - On r_ready with cnt==0: go to R_ADDR.
  - On r_ready with cnt!=0: cnt <= cnt-1.
- Beats per burst = ar_len+1:
  - ar_len=0 gives one beat with r_last=1.
  - ar_len=255 gives 256 beats, with r_last only on the 256th.
- First R beat is valid the cycle after AR acceptance.
- Once r_valid is asserted, r_id, r_data, r_resp and r_last stay stable until r_ready (no change while stalled).

Simultaneous events:
- AW and AR in the same cycle: both accepted. B and R proceed independently, with no ordering between paths.
- b_ready low, or r_ready low: the respective valid is held indefinitely with stable payload.

Reset:
- While rst=1: both FSMs forced to *_ADDR, and wid, rid, cnt cleared to 0.
- Resulting output values: b_valid=0, r_valid=0, w_ready=0, r_last=0, aw_ready=1, ar_ready=1. Valids are guaranteed low during reset.
- Reset asserted mid-burst: any in-flight transaction is abandoned with no B/R issued. After deassertion the block accepts new AW/AR from the next rising edge.

Test Plan:
- Single write: AW id=5 len=0, one W with w_last=1, b_ready=1. Required: one B with b_id=5, b_resp=2'b11, b_valid high exactly 1 cycle, aw_ready back high the following cycle.
- Write burst len=3: w_valid toggled 1/0 over 8 cycles, b_ready held 0 for 3 cycles after b_valid. Required: exactly 4 beats accepted, b_valid held with b_id stable, only one B.
- Read len=3, id=9: r_ready pattern 1,0,1,1,0,1. Required: exactly 4 beats, all r_id=9, r_resp=2'b11, r_data=R_DATA, payload stable through stalls, r_last only on the 4th.
- Read len=255 with r_ready=1. Required: 256 consecutive beats, r_last only on beat 256, ar_ready high on the next cycle. Also read len=0: one beat with r_last=1.
- AW id=1 and AR id=2 in the same cycle, plus W presented 2 cycles before any AW. Required: both accepted together and B/R carry the correct ids; early W sees w_ready=0 until AW is accepted.
- rst pulsed during beat 2 of a len=7 read and during W_DATA. Required: r_valid/b_valid drop to 0 immediately (async), aw_ready=ar_ready=1, and a new len=0 read completes normally after reset.

Source files
------------

// File: rtl/axi_error_slave_if.sv
// AXI4 channel bundle shared between a master and the error slave.
// Widths of ID/ADDR/DATA/USER are set by the interface parameters.
interface axi_channel #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int USER_W = 1
);
    logic [ID_W-1:0]     aw_id;
    logic [ADDR_W-1:0]   aw_addr;
    logic [7:0]          aw_len;
    logic [2:0]          aw_size;
    logic [1:0]          aw_burst;
    logic                aw_lock;
    logic [3:0]          aw_cache;
    logic [2:0]          aw_prot;
    logic [3:0]          aw_qos;
    logic [3:0]          aw_region;
    logic [USER_W-1:0]   aw_user;
    logic                aw_valid;
    logic                aw_ready;

    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_strb;
    logic                w_last;
    logic [USER_W-1:0]   w_user;
    logic                w_valid;
    logic                w_ready;

    logic [ID_W-1:0]     b_id;
    logic [1:0]          b_resp;
    logic [USER_W-1:0]   b_user;
    logic                b_valid;
    logic                b_ready;

    logic [ID_W-1:0]     ar_id;
    logic [ADDR_W-1:0]   ar_addr;
    logic [7:0]          ar_len;
    logic [2:0]          ar_size;
    logic [1:0]          ar_burst;
    logic                ar_lock;
    logic [3:0]          ar_cache;
    logic [2:0]          ar_prot;
    logic [3:0]          ar_qos;
    logic [3:0]          ar_region;
    logic [USER_W-1:0]   ar_user;
    logic                ar_valid;
    logic                ar_ready;

    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_data;
    logic [1:0]          r_resp;
    logic                r_last;
    logic [USER_W-1:0]   r_user;
    logic                r_valid;
    logic                r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
               aw_cache, aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
               ar_cache, ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
               aw_cache, aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
               ar_cache, ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi_error_slave.sv
// Terminating AXI4 slave: every write and read completes with RESP.
// One outstanding transaction per path; all outputs come from flops.
module axi_error_slave #(
    parameter logic [1:0]    RESP   = 2'b11,
    parameter logic [1023:0] R_DATA = '0
) (
    input logic         clk,
    input logic         rst,
    axi_channel.slave   master
);
    localparam int IW = $bits(master.aw_id);
    localparam int DW = $bits(master.r_data);

    typedef enum logic [1:0] {WR_ADDR, WR_DATA, WR_RESP} wr_state_t;
    typedef enum logic {RD_ADDR, RD_DATA} rd_state_t;

    wr_state_t       r_wr_state;
    logic [IW-1:0]   r_wid;
    logic            r_aw_ready;
    logic            r_w_ready;
    logic            r_b_valid;

    rd_state_t       r_rd_state;
    logic [IW-1:0]   r_rid;
    logic [7:0]      r_cnt;
    logic            r_ar_ready;
    logic            r_r_valid;
    logic            r_r_last;

    // Write path: handshake outputs are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_state <= WR_ADDR;
            r_wid      <= '0;
            r_aw_ready <= 1'b1;
            r_w_ready  <= 1'b0;
            r_b_valid  <= 1'b0;
        end else begin
            case (r_wr_state)
                WR_ADDR: begin
                    if (master.aw_valid) begin
                        r_wid      <= master.aw_id;
                        r_aw_ready <= 1'b0;
                        r_w_ready  <= 1'b1;
                        r_wr_state <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (master.w_valid && master.w_last) begin
                        r_w_ready  <= 1'b0;
                        r_b_valid  <= 1'b1;
                        r_wr_state <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (master.b_ready) begin
                        r_b_valid  <= 1'b0;
                        r_aw_ready <= 1'b1;
                        r_wr_state <= WR_ADDR;
                    end
                end
                default: begin
                    r_aw_ready <= 1'b1;
                    r_w_ready  <= 1'b0;
                    r_b_valid  <= 1'b0;
                    r_wr_state <= WR_ADDR;
                end
            endcase
        end
    end

    // Read path: r_cnt counts remaining beats after the current one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_state <= RD_ADDR;
            r_rid      <= '0;
            r_cnt      <= '0;
            r_ar_ready <= 1'b1;
            r_r_valid  <= 1'b0;
            r_r_last   <= 1'b0;
        end else begin
            case (r_rd_state)
                RD_ADDR: begin
                    if (master.ar_valid) begin
                        r_rid      <= master.ar_id;
                        r_cnt      <= master.ar_len;
                        r_r_last   <= (master.ar_len == 8'd0);
                        r_r_valid  <= 1'b1;
                        r_ar_ready <= 1'b0;
                        r_rd_state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (master.r_ready) begin
                        if (r_cnt == 8'd0) begin
                            r_r_valid  <= 1'b0;
                            r_r_last   <= 1'b0;
                            r_ar_ready <= 1'b1;
                            r_rd_state <= RD_ADDR;
                        end else begin
                            r_cnt    <= r_cnt - 8'd1;
                            r_r_last <= (r_cnt == 8'd1);
                        end
                    end
                end
                default: begin
                    r_r_valid  <= 1'b0;
                    r_r_last   <= 1'b0;
                    r_ar_ready <= 1'b1;
                    r_rd_state <= RD_ADDR;
                end
            endcase
        end
    end

    assign master.aw_ready = r_aw_ready;
    assign master.w_ready  = r_w_ready;
    assign master.b_valid  = r_b_valid;
    assign master.b_id     = r_wid;
    assign master.b_resp   = RESP;
    assign master.b_user   = '0;

    assign master.ar_ready = r_ar_ready;
    assign master.r_valid  = r_r_valid;
    assign master.r_id     = r_rid;
    assign master.r_last   = r_r_last;
    assign master.r_data   = R_DATA[DW-1:0];
    assign master.r_resp   = RESP;
    assign master.r_user   = '0;
endmodule

// File: tb/tb_axi_error_slave.sv
// Scoreboard bench for axi_error_slave: directed scenarios plus
// random traffic checked against a transaction-level model.
module tb_axi_error_slave;
    localparam int IDW = 4;
    localparam int DW  = 32;
    localparam int TMO = 2000;
    localparam logic [DW-1:0] EXP_RDATA = 32'hDEAD_BEEF;
    localparam logic [1:0]    EXP_RESP  = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_channel #(
        .ID_W(IDW), .ADDR_W(32), .DATA_W(DW), .USER_W(1)
    ) bus ();

    axi_error_slave #(
        .RESP(2'b11),
        .R_DATA(1024'hDEAD_BEEF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .master(bus)
    );

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           last;
    } rexp_t;

    logic [IDW-1:0] qb[$];
    rexp_t          qr[$];

    int n_cmp = 0;
    int n_err = 0;
    int w_acc = 0;
    int w_exp = 0;
    int b_cnt = 0;
    int r_cnt = 0;
    int bready_mode = 0;
    int rready_mode = 0;
    logic br_man = 1'b0;
    logic rr_man = 1'b0;
    time  t_aw, t_ar;

    function automatic void chk(string nm, logic [63:0] act,
                                logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     nm, act, exp, $time);
        end
    endfunction

    function automatic void tmo(string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timeout @%0t", nm, $time);
    endfunction

    // Ready drivers for B and R: always-on, random, or test controlled.
    always @(posedge clk) begin
        #2;
        case (bready_mode)
            0:       bus.b_ready = 1'b1;
            1:       bus.b_ready = 1'($urandom_range(0, 1));
            default: bus.b_ready = br_man;
        endcase
        case (rready_mode)
            0:       bus.r_ready = 1'b1;
            1:       bus.r_ready = 1'($urandom_range(0, 1));
            default: bus.r_ready = rr_man;
        endcase
    end

    logic           b_stall, r_stall;
    logic [IDW-1:0] b_id_h, r_id_h;
    logic           r_last_h;
    logic [IDW-1:0] be;
    rexp_t          re;

    // Monitor: pops the model queues whenever a handshake is presented.
    always @(negedge clk) begin
        if (rst) begin
            b_stall = 1'b0;
            r_stall = 1'b0;
        end else begin
            if (bus.w_valid && bus.w_ready) w_acc++;
            if (b_stall) begin
                chk("b_hold_valid", 64'(bus.b_valid), 64'd1);
                chk("b_hold_id", 64'(bus.b_id), 64'(b_id_h));
            end
            b_stall = 1'b0;
            if (bus.b_valid) begin
                chk("b_resp", 64'(bus.b_resp), 64'(EXP_RESP));
                chk("b_user", 64'(bus.b_user), 64'd0);
                if (bus.b_ready) begin
                    b_cnt++;
                    if (qb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL b_unexpected: id %0h", bus.b_id);
                    end else begin
                        be = qb.pop_front();
                        chk("b_id", 64'(bus.b_id), 64'(be));
                    end
                end else begin
                    b_stall = 1'b1;
                    b_id_h  = bus.b_id;
                end
            end
            if (r_stall) begin
                chk("r_hold_valid", 64'(bus.r_valid), 64'd1);
                chk("r_hold_id", 64'(bus.r_id), 64'(r_id_h));
                chk("r_hold_last", 64'(bus.r_last), 64'(r_last_h));
            end
            r_stall = 1'b0;
            if (bus.r_valid) begin
                chk("r_resp", 64'(bus.r_resp), 64'(EXP_RESP));
                chk("r_data", 64'(bus.r_data), 64'(EXP_RDATA));
                chk("r_user", 64'(bus.r_user), 64'd0);
                if (bus.r_ready) begin
                    r_cnt++;
                    if (qr.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL r_unexpected: id %0h", bus.r_id);
                    end else begin
                        re = qr.pop_front();
                        chk("r_id", 64'(bus.r_id), 64'(re.id));
                        chk("r_last", 64'(bus.r_last), 64'(re.last));
                    end
                end else begin
                    r_stall  = 1'b1;
                    r_id_h   = bus.r_id;
                    r_last_h = bus.r_last;
                end
            end
        end
    end

    task automatic do_aw(input logic [IDW-1:0] id, input int nb);
        int k;
        @(posedge clk);
        #1;
        bus.aw_id    = id;
        bus.aw_len   = 8'(nb - 1);
        bus.aw_addr  = $urandom;
        bus.aw_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!bus.aw_ready && k < TMO) begin
            @(negedge clk);
            k++;
        end
        if (k >= TMO) tmo("aw_accept");
        qb.push_back(id);
        t_aw = $time;
        @(posedge clk);
        #1;
        bus.aw_valid = 1'b0;
    endtask

    task automatic do_w(input int nb, input int gapmax);
        int k;
        for (int b = 0; b < nb; b++) begin
            repeat ($urandom_range(0, gapmax)) begin
                bus.w_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            bus.w_valid = 1'b1;
            bus.w_last  = (b == nb - 1);
            bus.w_data  = $urandom;
            w_exp++;
            k = 0;
            @(negedge clk);
            while (!bus.w_ready && k < TMO) begin
                @(negedge clk);
                k++;
            end
            if (k >= TMO) tmo("w_accept");
            @(posedge clk);
            #1;
        end
        bus.w_valid = 1'b0;
        bus.w_last  = 1'b0;
    endtask

    task automatic do_ar(input logic [IDW-1:0] id, input logic [7:0] len);
        int k;
        @(posedge clk);
        #1;
        bus.ar_id    = id;
        bus.ar_len   = len;
        bus.ar_addr  = $urandom;
        bus.ar_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!bus.ar_ready && k < TMO) begin
            @(negedge clk);
            k++;
        end
        if (k >= TMO) tmo("ar_accept");
        for (int i = 0; i <= int'(len); i++)
            qr.push_back('{id: id, last: (i == int'(len))});
        t_ar = $time;
        @(posedge clk);
        #1;
        bus.ar_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while ((qb.size() != 0 || qr.size() != 0) && k < TMO) begin
            @(posedge clk);
            k++;
        end
        if (k >= TMO) tmo(nm);
        repeat (2) @(posedge clk);
        #1;
    endtask

    int k;
    int w0, b0, r0;
    logic [5:0] pat;

    initial begin
        bus.aw_valid = 0; bus.aw_id = '0; bus.aw_addr = '0;
        bus.aw_len = '0; bus.aw_size = '0; bus.aw_burst = '0;
        bus.aw_lock = 0; bus.aw_cache = '0; bus.aw_prot = '0;
        bus.aw_qos = '0; bus.aw_region = '0; bus.aw_user = '0;
        bus.w_valid = 0; bus.w_data = '0; bus.w_strb = '1;
        bus.w_last = 0; bus.w_user = '0;
        bus.ar_valid = 0; bus.ar_id = '0; bus.ar_addr = '0;
        bus.ar_len = '0; bus.ar_size = '0; bus.ar_burst = '0;
        bus.ar_lock = 0; bus.ar_cache = '0; bus.ar_prot = '0;
        bus.ar_qos = '0; bus.ar_region = '0; bus.ar_user = '0;
        bus.b_ready = 0; bus.r_ready = 0;

        #12;
        chk("rst_b_valid", 64'(bus.b_valid), 64'd0);
        chk("rst_r_valid", 64'(bus.r_valid), 64'd0);
        chk("rst_w_ready", 64'(bus.w_ready), 64'd0);
        chk("rst_r_last", 64'(bus.r_last), 64'd0);
        chk("rst_aw_ready", 64'(bus.aw_ready), 64'd1);
        chk("rst_ar_ready", 64'(bus.ar_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single write, id 5
        b0 = b_cnt;
        do_aw(4'd5, 1);
        do_w(1, 0);
        @(negedge clk);
        chk("w1_b_valid", 64'(bus.b_valid), 64'd1);
        @(negedge clk);
        chk("w1_b_drop", 64'(bus.b_valid), 64'd0);
        chk("w1_aw_ready", 64'(bus.aw_ready), 64'd1);
        chk("w1_b_count", 64'(b_cnt - b0), 64'd1);

        // Burst of 4 with toggled w_valid and stalled b_ready
        bready_mode = 2;
        br_man = 1'b0;
        w0 = w_acc;
        b0 = b_cnt;
        do_aw(4'd7, 4);
        for (int c = 0; c < 8; c++) begin
            bus.w_valid = (c % 2 == 0);
            bus.w_last  = (c == 6);
            @(posedge clk);
            #1;
        end
        bus.w_valid = 1'b0;
        bus.w_last  = 1'b0;
        w_exp += 4;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        br_man = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("burst_beats", 64'(w_acc - w0), 64'd4);
        chk("burst_b_count", 64'(b_cnt - b0), 64'd1);
        bready_mode = 0;

        // Read len 3 with stalled r_ready
        rready_mode = 2;
        pat = 6'b101101;
        rr_man = 1'b1;
        r0 = r_cnt;
        do_ar(4'd9, 8'd3);
        for (int i = 0; i < 6; i++) begin
            rr_man = pat[5 - i];
            @(posedge clk);
            #1;
        end
        rr_man = 1'b0;
        @(negedge clk);
        chk("rd3_beats", 64'(r_cnt - r0), 64'd4);
        chk("rd3_done", 64'(bus.r_valid), 64'd0);
        chk("rd3_ar_ready", 64'(bus.ar_ready), 64'd1);
        rready_mode = 0;

        // Read len 255 then len 0, r_ready held high
        do_ar(4'd12, 8'd255);
        k = 0;
        @(negedge clk);
        while (bus.r_valid && k < 300) begin
            k++;
            @(negedge clk);
        end
        chk("rd255_beats", 64'(k), 64'd256);
        chk("rd255_ar_ready", 64'(bus.ar_ready), 64'd1);
        do_ar(4'd3, 8'd0);
        k = 0;
        @(negedge clk);
        while (bus.r_valid && k < 300) begin
            k++;
            @(negedge clk);
        end
        chk("rd0_beats", 64'(k), 64'd1);

        // Early W, then AW and AR in the same cycle
        @(posedge clk);
        #1;
        bus.w_valid = 1'b1;
        bus.w_last  = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("early_w_ready", 64'(bus.w_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        fork
            do_aw(4'd1, 1);
            do_ar(4'd2, 8'd0);
        join
        chk("aw_ar_same", 64'(t_aw), 64'(t_ar));
        @(negedge clk);
        chk("late_w_ready", 64'(bus.w_ready), 64'd1);
        w_exp++;
        @(posedge clk);
        #1;
        bus.w_valid = 1'b0;
        bus.w_last  = 1'b0;
        drain("drain_simul");

        // Reset mid read burst and during write data phase
        do_aw(4'd3, 1);
        do_ar(4'd6, 8'd7);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_r_valid", 64'(bus.r_valid), 64'd0);
        chk("mid_rst_b_valid", 64'(bus.b_valid), 64'd0);
        chk("mid_rst_w_ready", 64'(bus.w_ready), 64'd0);
        chk("mid_rst_aw_ready", 64'(bus.aw_ready), 64'd1);
        chk("mid_rst_ar_ready", 64'(bus.ar_ready), 64'd1);
        qb.delete();
        qr.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        r0 = r_cnt;
        do_ar(4'd4, 8'd0);
        drain("drain_post_rst");
        chk("post_rst_read", 64'(r_cnt - r0), 64'd1);

        // Random concurrent traffic
        bready_mode = 1;
        rready_mode = 1;
        fork
            begin
                int nb;
                repeat (15) begin
                    nb = $urandom_range(1, 8);
                    do_aw(4'($urandom_range(0, 15)), nb);
                    do_w(nb, 2);
                end
            end
            begin
                repeat (15)
                    do_ar(4'($urandom_range(0, 15)),
                          8'($urandom_range(0, 20)));
            end
        join
        drain("drain_random");
        chk("w_beats_total", 64'(w_acc), 64'(w_exp));
        chk("queues_empty", 64'(qb.size() + qr.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
